// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers
module muldiv_unit #(
  parameter int              WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q;
  logic [1:0]         op_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic               div0_q;
  logic [WIDTH-1:0]   opb_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q;
  logic [CW-1:0]      count_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               in_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic               q_signed;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // op[0]=1 selects the unsigned variants; magnitudes are taken only for signed ops
  always_comb begin
    in_signed = ~op[0];
    abs_a     = (in_signed && srca[WIDTH-1]) ? -srca : srca;
    abs_b     = (in_signed && srcb[WIDTH-1]) ? -srcb : srcb;
  end

  // Shift-add: the multiplier sits in the low half of acc and is consumed LSB first
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Restoring divide: dividend shifts out of acc's low half while quotient bits shift in
  always_comb begin
    rem_sh   = {rem_q, acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    div_ge   = ~rem_diff[WIDTH];
    rem_next = div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_next = {acc_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    q_signed = ~op_q[0];
    prod_fix = (q_signed && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
    quo_fix  = (q_signed && (sign_a_q ^ sign_b_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = (q_signed && sign_a_q) ? -rem_q : rem_q;
    if (op_q[1]) begin
      fix_hi = rem_fix;
      fix_lo = div0_q ? DIV0_LO : quo_fix;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q     <= op;
            sign_a_q <= in_signed & srca[WIDTH-1];
            sign_b_q <= in_signed & srcb[WIDTH-1];
            div0_q   <= (srcb == '0);
            opb_q    <= abs_b;
            acc_q    <= {{WIDTH{1'b0}}, abs_a};
            rem_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            if (mthi) hi_q <= srca;
            if (mtlo) lo_q <= srca;
          end
        end
        S_RUN: begin
          if (op_q[1]) begin
            acc_q[WIDTH-1:0] <= quo_next;
            rem_q            <= rem_next;
          end else begin
            acc_q <= mul_next;
          end
          count_q <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  muldiv_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .srca    (srca),
    .srcb    (srcb),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic, returns {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    logic [31:0] q;
    logic [31:0] r;
    case (o)
      2'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      2'd1: begin
        up = {32'b0, a} * {32'b0, b};
        return up;
      end
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 100));
      default: return $urandom;
    endcase
  endfunction

  // Launches one op, scrambles the operand inputs after the start edge, waits for done
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output int lat, output int bcyc);
    @(negedge clk);
    op = o; srca = a; srcb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); srca = $urandom; srcb = $urandom;
    lat  = 0;
    bcyc = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (busy === 1'b1) bcyc++;
    end
    rh = hi;
    rl = lo;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; op = 2'd0; srca = '0; srcb = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [5] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [31:0] as  [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'h00001234};
    logic [31:0] bs  [5] = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd0};
    logic [31:0] ehi [5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'h00001234};
    logic [31:0] elo [5] = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] rh, rl;
    int lat, bcyc;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], rh, rl, lat, bcyc);
      checks++; if (rh !== ehi[i]) begin failures++; $display("FAIL dir%0d_hi got=%h exp=%h", i, rh, ehi[i]); end
      checks++; if (rl !== elo[i]) begin failures++; $display("FAIL dir%0d_lo got=%h exp=%h", i, rl, elo[i]); end
      checks++; if (lat != 33) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=33", i, lat); end
      checks++; if (bcyc != 33) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d exp=33", i, bcyc); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done); end
      checks++; if (rh !== hi || rl !== lo) begin failures++; $display("FAIL dir%0d_hold got=%h_%h exp=%h_%h", i, hi, lo, rh, rl); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, rh, rl;
    logic [63:0] exp;
    int lat, bcyc;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      exp = model(o, a, b);
      run_op(o, a, b, rh, rl, lat, bcyc);
      checks++;
      if ({rh, rl} !== exp || lat != 33) begin
        failures++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got=%h_%h lat=%0d exp=%h lat=33", i, o, a, b, rh, rl, lat, exp);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    op = 2'd1; srca = 32'd2; srcb = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    repeat (9) begin @(posedge clk); lat++; end
    #1;
    op = 2'd1; srca = 32'd5; srcb = 32'd5; start = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    lat++;
    start = 1'b0; mtlo = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_hold got=%b exp=1", busy); end
    while (done !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    checks++; if (lo !== 32'd6) begin failures++; $display("FAIL ignore_lo got=%h exp=6", lo); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL ignore_hi got=%h exp=0", hi); end
    checks++; if (lat != 33) begin failures++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
  endtask

  task automatic test_mthi_mtlo();
    int lat;
    @(negedge clk);
    srca = 32'hC0DEBABE; mthi = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0;
    checks++; if (hi !== 32'hC0DEBABE) begin failures++; $display("FAIL mthi_hi got=%h exp=c0debabe", hi); end
    checks++; if (lo !== 32'd6) begin failures++; $display("FAIL mthi_lo got=%h exp=6", lo); end
    @(negedge clk);
    op = 2'd1; srca = 32'd11; srcb = 32'd2; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    checks++; if (hi !== 32'hC0DEBABE || lo !== 32'd6) begin
      failures++; $display("FAIL start_priority got=%h_%h exp=c0debabe_00000006", hi, lo);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    checks++; if (lo !== 32'd22 || hi !== 32'd0) begin failures++; $display("FAIL priority_result got=%h_%h exp=0_16", hi, lo); end
    @(negedge clk);
    srca = 32'h12345678; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    checks++; if (hi !== 32'h12345678 || lo !== 32'h12345678) begin
      failures++; $display("FAIL mthi_mtlo_both got=%h_%h exp=12345678_12345678", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rh, rl;
    int lat, bcyc;
    run_op(2'd0, 32'hFFFFFF00, 32'h00000100, rh, rl, lat, bcyc);
    checks++; if ({rh, rl} !== model(2'd0, 32'hFFFFFF00, 32'h00000100)) begin
      failures++; $display("FAIL b2b_first got=%h_%h exp=%h", rh, rl, model(2'd0, 32'hFFFFFF00, 32'h00000100));
    end
    run_op(2'd2, 32'd100, 32'hFFFFFFF9, rh, rl, lat, bcyc);
    checks++; if ({rh, rl} !== model(2'd2, 32'd100, 32'hFFFFFFF9) || lat != 33) begin
      failures++; $display("FAIL b2b_second got=%h_%h lat=%0d exp=%h lat=33", rh, rl, lat, model(2'd2, 32'd100, 32'hFFFFFFF9));
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rh, rl;
    int lat, bcyc;
    @(negedge clk);
    op = 2'd3; srca = 32'hDEADBEEF; srcb = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL arst_hilo got=%h_%h exp=0_0", hi, lo); end
    @(negedge clk);
    reset_n = 1'b1;
    run_op(2'd3, 32'd100, 32'd7, rh, rl, lat, bcyc);
    checks++; if (rl !== 32'd14 || rh !== 32'd2) begin failures++; $display("FAIL post_reset_divu got=%h_%h exp=2_e", rh, rl); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_mthi_mtlo();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
